div_sequencer: RTL and testbench



---
 rtl/div_sequencer_if.sv | 23 ++
 rtl/div_sequencer.sv | 103 ++++++++++
 tb/tb_div_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// Handshake bundle between the EX-stage pipeline control and the divide
// sequencer. The pipeline side is the master: it presents the DIV request
// and the divisor-zero qualifier, and consumes the stall/divider/HiLo controls.
interface div_sequencer_if;
  logic       div_req;
  logic       divisor_zero;
  logic       stall;
  logic       div_rst;
  logic       hilo_we;
  logic       busy;
  logic       dz_err;
  logic [5:0] cnt;

  modport master (
    output div_req, divisor_zero,
    input  stall, div_rst, hilo_we, busy, dz_err, cnt
  );

  modport slave (
    input  div_req, divisor_zero,
    output stall, div_rst, hilo_we, busy, dz_err, cnt
  );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer. It freezes the front of the pipeline while
// an iterative divider runs for DIV_CYCLES cycles, then pulses the HiLo write
// in the same cycle the DIV is released from EX. A zero divisor skips the
// divider entirely and raises a sticky error flag instead of touching HiLo.
// DIV_CYCLES must lie in 2..63 so the count fits the 6-bit cnt output.
module div_sequencer #(
  parameter int DIV_CYCLES = 32
) (
  input  logic           clk,
  input  logic           rst,
  div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WRITE,
    DZ
  } state_t;

  localparam logic [5:0] LAST_CNT = 6'(DIV_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [5:0] cnt_reg, cnt_next;
  logic       dz_err_reg, dz_err_next;

  logic       stall_c;
  logic       div_rst_c;
  logic       hilo_we_c;

  // State, iteration count and sticky error flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 6'd0;
      dz_err_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      dz_err_reg <= dz_err_next;
    end
  end

  // Next-state logic and control decode; stall/div_rst in IDLE depend on the
  // live request so the DIV is frozen in EX from its very first cycle.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    dz_err_next = dz_err_reg;
    stall_c     = 1'b0;
    div_rst_c   = 1'b0;
    hilo_we_c   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.div_req) begin
          stall_c = 1'b1;
          if (bus.divisor_zero) begin
            state_next = DZ;
          end else begin
            div_rst_c  = 1'b1;
            state_next = RUN;
            cnt_next   = 6'd0;
          end
        end
      end
      RUN: begin
        // The request may drop here; the divider is already committed.
        stall_c = 1'b1;
        if (cnt_reg == LAST_CNT) begin
          state_next = WRITE;
          cnt_next   = 6'd0;
        end else begin
          cnt_next = cnt_reg + 6'd1;
        end
      end
      WRITE: begin
        // Releasing stall here lets the DIV leave EX on the HiLo write edge,
        // so a following MFHI/MFLO reads the fresh value without extra stall.
        hilo_we_c  = 1'b1;
        state_next = IDLE;
      end
      DZ: begin
        dz_err_next = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 6'd0;
      end
    endcase
  end

  // Pipeline controls are forced inactive while reset is held so an aborted
  // DIV can never leak a stall, restart or HiLo write.
  assign bus.stall   = stall_c   & ~rst;
  assign bus.div_rst = div_rst_c & ~rst;
  assign bus.hilo_we = hilo_we_c & ~rst;
  assign bus.busy    = (state_reg != IDLE) & ~rst;
  assign bus.dz_err  = dz_err_reg;
  assign bus.cnt     = cnt_reg;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: a directed per-cycle vector table, hand-written
// multi-cycle sequences, a DIV_CYCLES=2 instance, and a randomized run
// checked against a timeline model of each accepted DIV.
module tb_div_sequencer;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_sequencer_if bus_a ();
  div_sequencer_if bus_b ();

  div_sequencer #(.DIV_CYCLES(N)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  div_sequencer #(.DIV_CYCLES(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int tests = 0;
  int fails = 0;

  // Downstream HiLo register fed by the divider result on hilo_we.
  logic [31:0] op_a = 32'd17;
  logic [31:0] op_b = 32'd5;
  logic [31:0] hi = 32'd0;
  logic [31:0] lo = 32'd0;
  always @(posedge clk) begin
    if (bus_a.hilo_we && op_b != 0) begin
      hi <= op_a % op_b;
      lo <= op_a / op_b;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic int pack_a();
    return int'({bus_a.stall, bus_a.div_rst, bus_a.hilo_we, bus_a.busy, bus_a.dz_err, bus_a.cnt});
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst, req, dz;
    bit stall, div_rst, hilo_we, busy, dz_err;
    int cnt;
  } vec_t;

  // Normal DIV from IDLE: checks restart pulse, stall window, HiLo write
  // cycle, and the value an MFLO released by that stall would read.
  task automatic run_normal(input [31:0] a, input [31:0] b, input int exp_hi,
                            input int exp_lo, input string tag);
    int nrst = 0, rst_cyc = -1, nstall = 0, nstall_early = 0;
    int nhilo = 0, hilo_cyc = -1;
    int rfval = 32'hDEAD;
    op_a = a;
    op_b = b;
    bus_a.div_req = 1'b1;
    bus_a.divisor_zero = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_a.stall) begin
        nstall++;
        if (k <= N) nstall_early++;
      end
      if (bus_a.div_rst) begin
        nrst++;
        rst_cyc = k;
      end
      if (hilo_cyc >= 0 && k == hilo_cyc + 1) rfval = int'(lo);
      if (bus_a.hilo_we) begin
        nhilo++;
        hilo_cyc = k;
      end
      next_cycle();
      if (k == N + 1) bus_a.div_req = 1'b0;
    end
    chk({tag, "_div_rst_count"}, nrst, 1);
    chk({tag, "_div_rst_cycle"}, rst_cyc, 0);
    chk({tag, "_stall_total"}, nstall, N + 1);
    chk({tag, "_stall_contiguous"}, nstall_early, N + 1);
    chk({tag, "_hilo_we_count"}, nhilo, 1);
    chk({tag, "_hilo_we_cycle"}, hilo_cyc, N + 1);
    chk({tag, "_hi"}, int'(hi), exp_hi);
    chk({tag, "_lo"}, int'(lo), exp_lo);
    chk({tag, "_mflo_rd"}, rfval, exp_lo);
  endtask

  initial begin
    vec_t tbl[9];
    int hilo_q[$];
    int low_q[$];
    int cnt_q[$];
    int fired, n, nst, hc;
    bit in_seq, kind_dz, dz_err_m, q, z, r;
    int start, cyc, d, e_cnt;
    bit e_stall, e_rst, e_we, e_busy;

    // rst req dz | stall div_rst hilo_we busy dz_err cnt
    tbl[0] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 1, 0, 0, 0, 1, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[5] = '{0, 1, 0, 1, 1, 0, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 1, 0, 0, 1, 1, 0};
    tbl[7] = '{1, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    bus_a.div_req = 1'b0;
    bus_a.divisor_zero = 1'b0;
    bus_b.div_req = 1'b0;
    bus_b.divisor_zero = 1'b0;
    next_cycle();
    next_cycle();

    // Directed per-cycle vectors: reset gating, DZ path, dropped request,
    // reset abort and sticky-flag clear.
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst;
      bus_a.div_req = tbl[i].req;
      bus_a.divisor_zero = tbl[i].dz;
      @(negedge clk);
      chk($sformatf("vec%0d", i), pack_a(),
          int'({tbl[i].stall, tbl[i].div_rst, tbl[i].hilo_we, tbl[i].busy,
                tbl[i].dz_err, 6'(tbl[i].cnt)}));
      next_cycle();
    end
    rst = 1'b0;
    bus_a.div_req = 1'b0;

    run_normal(32'd17, 32'd5, 2, 3, "div17_5");

    // Back-to-back: request held across the WRITE cycle.
    bus_a.div_req = 1'b1;
    for (int k = 0; k < 75; k++) begin
      @(negedge clk);
      if (bus_a.hilo_we) hilo_q.push_back(k);
      if (k <= 2 * N + 3 && !bus_a.stall) low_q.push_back(k);
      next_cycle();
      if (k == 2 * N + 3) bus_a.div_req = 1'b0;
    end
    chk("b2b_hilo_count", hilo_q.size(), 2);
    chk("b2b_hilo_gap", (hilo_q.size() == 2) ? hilo_q[1] - hilo_q[0] : -1, N + 2);
    chk("b2b_stall_low_count", low_q.size(), 2);
    chk("b2b_stall_low_first", (low_q.size() >= 1) ? low_q[0] : -1, N + 1);
    chk("b2b_stall_low_second", (low_q.size() >= 2) ? low_q[1] : -1, 2 * N + 3);

    // Reset mid-run at cnt==10.
    fired = 0;
    n = 0;
    bus_a.div_req = 1'b1;
    for (int k = 0; k < 60 && fired == 0; k++) begin
      @(negedge clk);
      if (bus_a.hilo_we) n++;
      if (bus_a.busy && bus_a.cnt == 6'd10) begin
        rst = 1'b1;
        bus_a.div_req = 1'b0;
        fired = 1;
      end
      next_cycle();
    end
    rst = 1'b0;
    chk("rstmid_reached_cnt10", fired, 1);
    @(negedge clk);
    chk("rstmid_busy", int'(bus_a.busy), 0);
    chk("rstmid_cnt", int'(bus_a.cnt), 0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_a.hilo_we) n++;
      next_cycle();
    end
    chk("rstmid_no_hilo_we", n, 0);

    run_normal(32'd100, 32'd7, 2, 14, "divu100_7");

    // DIV_CYCLES=2 instance.
    nst = 0;
    n = 0;
    hc = -1;
    bus_b.div_req = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (bus_b.stall) nst++;
      if (bus_b.stall && bus_b.busy) cnt_q.push_back(int'(bus_b.cnt));
      if (bus_b.hilo_we) begin
        n++;
        hc = k;
      end
      next_cycle();
      if (k == 2) bus_b.div_req = 1'b0;
    end
    chk("n2_stall_cycles", nst, 3);
    chk("n2_cnt_len", cnt_q.size(), 2);
    chk("n2_cnt_first", (cnt_q.size() >= 1) ? cnt_q[0] : -1, 0);
    chk("n2_cnt_second", (cnt_q.size() >= 2) ? cnt_q[1] : -1, 1);
    chk("n2_hilo_count", n, 1);
    chk("n2_hilo_cycle", hc, 3);

    // Randomized run against a timeline model: each accepted DIV is an
    // event at cycle 'start'; outputs follow from the offset since then.
    rst = 1'b1;
    bus_a.div_req = 1'b0;
    next_cycle();
    rst = 1'b0;
    in_seq = 1'b0;
    kind_dz = 1'b0;
    dz_err_m = 1'b0;
    start = 0;
    cyc = 0;
    for (int t = 0; t < 500; t++) begin
      q = ($urandom_range(0, 3) != 0);
      z = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 60) == 0);
      rst = r;
      bus_a.div_req = q;
      bus_a.divisor_zero = z;
      @(negedge clk);
      d = cyc - start;
      e_stall = 1'b0;
      e_rst = 1'b0;
      e_we = 1'b0;
      e_busy = 1'b0;
      e_cnt = 0;
      if (in_seq && !kind_dz && d >= 1 && d <= N) e_cnt = d - 1;
      if (!r) begin
        if (!in_seq) begin
          e_stall = q;
          e_rst = q && !z;
        end else begin
          e_busy = 1'b1;
          if (!kind_dz) begin
            if (d <= N) e_stall = 1'b1;
            else e_we = 1'b1;
          end
        end
      end
      chk($sformatf("rand%0d", t), pack_a(),
          int'({e_stall, e_rst, e_we, e_busy, dz_err_m, 6'(e_cnt)}));
      if (r) begin
        in_seq = 1'b0;
        dz_err_m = 1'b0;
      end else if (!in_seq) begin
        if (q) begin
          in_seq = 1'b1;
          start = cyc;
          kind_dz = z;
        end
      end else if (kind_dz) begin
        in_seq = 1'b0;
        dz_err_m = 1'b1;
      end else if (d == N + 1) begin
        in_seq = 1'b0;
      end
      cyc++;
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
